// File: rtl/mod_div_unit_if.sv
// Start/busy/done handshake bundle between a requesting FSM and mod_div_unit.
interface mod_div_unit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] remainder;
  logic [WIDTH-1:0] quotient;
  logic             div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, remainder, quotient, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, remainder, quotient, div_zero
  );
endinterface

// File: rtl/mod_div_unit.sv
// Iterative unsigned modulo/divide by repeated subtraction, one step per clock.
// Define MOD_DIV_QUOTIENT_EN to build the quotient counter; otherwise quotient reads 0.
module mod_div_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  mod_div_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] remainder_r;
  logic             busy_r;
  logic             done_r;
  logic             div_zero_r;

`ifdef MOD_DIV_QUOTIENT_EN
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] quotient_r;

  // Quotient counter: cleared on accept, counts subtractions, captured on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      q          <= '0;
      quotient_r <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) q <= '0;
        ST_RUN: begin
          if (b == '0)      quotient_r <= '0;
          else if (a < b)   quotient_r <= q;
          else              q          <= q + WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient = quotient_r;
`else
  assign bus.quotient = '0;
`endif

  // Control and remainder datapath; priority in RUN is divide-by-zero, then finish, then subtract.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      a           <= '0;
      b           <= '0;
      remainder_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      div_zero_r  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a          <= bus.dividend;
            b          <= bus.divisor;
            div_zero_r <= 1'b0;
            busy_r     <= 1'b1;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (b == '0) begin
            remainder_r <= a;
            div_zero_r  <= 1'b1;
            done_r      <= 1'b1;
            state       <= ST_DONE;
          end else if (a < b) begin
            remainder_r <= a;
            done_r      <= 1'b1;
            state       <= ST_DONE;
          end else begin
            a <= a - b;
          end
        end
        ST_DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.remainder = remainder_r;
  assign bus.div_zero  = div_zero_r;

endmodule

// File: tb/tb_mod_div_unit.sv
// Self-checking bench for mod_div_unit: directed vector table, corner sequences, random ops vs model.
module tb_mod_div_unit;

  localparam int unsigned WIDTH = 8;
`ifdef MOD_DIV_QUOTIENT_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mod_div_unit_if #(.WIDTH(WIDTH)) bus ();

  mod_div_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int dd;
    int dv;
    int rem;
    int quo;
    int dz;
    int lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected result from the arithmetic definition of the operation.
  function automatic void model(input int dd, input int dv,
                                output int rem, output int quo, output int dz, output int lat);
    if (dv == 0) begin
      rem = dd; quo = 0; dz = 1; lat = 2;
    end else begin
      rem = dd % dv; quo = dd / dv; dz = 0; lat = dd / dv + 2;
    end
  endfunction

  // Issue one op from IDLE (called at posedge+1) and check results, latency, busy and the done pulse.
  task automatic do_op(input string name, input int dd, input int dv,
                       input int e_rem, input int e_quo, input int e_dz, input int e_lat);
    int lat;
    bit busy_ok;
    bus.start    = 1'b1;
    bus.dividend = WIDTH'(dd);
    bus.divisor  = WIDTH'(dv);
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat     = 1;
    busy_ok = bus.busy;
    while (!bus.done && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (!bus.busy) busy_ok = 1'b0;
    end
    chk({name, ".lat"},  lat, e_lat);
    chk({name, ".busy"}, int'(busy_ok), 1);
    chk({name, ".rem"},  int'(bus.remainder), e_rem);
    chk({name, ".quo"},  int'(bus.quotient), QEN ? e_quo : 0);
    chk({name, ".dz"},   int'(bus.div_zero), e_dz);
    @(posedge clk); #1;
    chk({name, ".done_pulse"}, int'(bus.done), 0);
    chk({name, ".busy_drop"},  int'(bus.busy), 0);
  endtask

  initial begin
    int lat;
    int r_rem, r_quo, r_dz, r_lat;
    int dd, dv;
    bit saw_done;

    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    vecs[0] = '{dd: 17,  dv: 5, rem: 2,   quo: 3,   dz: 0, lat: 5};
    vecs[1] = '{dd: 3,   dv: 7, rem: 3,   quo: 0,   dz: 0, lat: 2};
    vecs[2] = '{dd: 7,   dv: 7, rem: 0,   quo: 1,   dz: 0, lat: 3};
    vecs[3] = '{dd: 100, dv: 0, rem: 100, quo: 0,   dz: 1, lat: 2};
    vecs[4] = '{dd: 9,   dv: 4, rem: 1,   quo: 2,   dz: 0, lat: 4};
    vecs[5] = '{dd: 255, dv: 1, rem: 0,   quo: 255, dz: 0, lat: 257};
    vecs[6] = '{dd: 0,   dv: 9, rem: 0,   quo: 0,   dz: 0, lat: 2};

    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", int'(bus.busy), 0);
    chk("rst.done", int'(bus.done), 0);
    chk("rst.rem",  int'(bus.remainder), 0);
    chk("rst.quo",  int'(bus.quotient), 0);
    chk("rst.dz",   int'(bus.div_zero), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      do_op($sformatf("vec%0d", i), vecs[i].dd, vecs[i].dv,
            vecs[i].rem, vecs[i].quo, vecs[i].dz, vecs[i].lat);

    // 200/3 with start pulses in RUN and in DONE that must be ignored.
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    repeat (5) begin @(posedge clk); #1; lat++; end
    bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
    @(posedge clk); #1; lat++;
    bus.start = 1'b0;
    while (!bus.done && lat < 400) begin @(posedge clk); #1; lat++; end
    chk("ign.lat", lat, 68);
    chk("ign.rem", int'(bus.remainder), 2);
    chk("ign.quo", int'(bus.quotient), QEN ? 66 : 0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ign.busy", int'(bus.busy), 0);
    chk("ign.rem_hold", int'(bus.remainder), 2);

    // Reset in the middle of 200/3 aborts with no done pulse.
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort.busy", int'(bus.busy), 0);
    chk("abort.done", int'(bus.done), 0);
    chk("abort.rem",  int'(bus.remainder), 0);
    chk("abort.quo",  int'(bus.quotient), 0);
    chk("abort.dz",   int'(bus.div_zero), 0);
    saw_done = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (bus.done || bus.busy) saw_done = 1'b1; end
    chk("abort.quiet", int'(saw_done), 0);
    do_op("post_abort", 10, 4, 2, 2, 0, 4);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      dd = int'($urandom_range(0, 255));
      if (i % 4 == 0) dv = int'($urandom_range(0, 255));
      else            dv = int'($urandom_range(0, 12));
      model(dd, dv, r_rem, r_quo, r_dz, r_lat);
      do_op($sformatf("rnd%0d_%0d_%0d", i, dd, dv), dd, dv, r_rem, r_quo, r_dz, r_lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
